// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed driver for an 8-digit common-anode 7-segment display.
// The display word is captured once per scan frame so a frame never mixes old and new digits.
module seg7_scan_ctrl #(
  parameter int SCAN_DIV  = 100000,
  parameter int GHOST_CYC = 16,
  parameter int LZB       = 0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] i_data,
  input  logic        disp_mode,
  input  logic        blank,
  output logic [7:0]  o_seg,
  output logic [7:0]  o_sel,
  output logic        o_frame
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   shadow_q, shadow_d;
  logic          mode_q, mode_d;
  logic [7:0]    seg_q, seg_d;
  logic [7:0]    sel_q, sel_d;
  logic          frame_q, frame_d;

  logic          tick;
  logic          frame_tick;
  logic [3:0]    nib;
  logic [7:0]    raw_byte;
  logic [7:0]    hex_pat;
  logic          digit_off;
  logic          slot_off;

  assign tick       = (cnt_q == CW'(SCAN_DIV - 1));
  assign frame_tick = tick && (idx_q == 3'd7);

  assign nib      = shadow_q[{idx_q, 2'b00} +: 4];
  assign raw_byte = shadow_q[{idx_q[1:0], 3'b000} +: 8];

  always_comb begin
    hex_pat = 8'hFF;
    case (nib)
      4'h0: hex_pat = 8'hC0;
      4'h1: hex_pat = 8'hF9;
      4'h2: hex_pat = 8'hA4;
      4'h3: hex_pat = 8'hB0;
      4'h4: hex_pat = 8'h99;
      4'h5: hex_pat = 8'h92;
      4'h6: hex_pat = 8'h82;
      4'h7: hex_pat = 8'hF8;
      4'h8: hex_pat = 8'h80;
      4'h9: hex_pat = 8'h90;
      4'hA: hex_pat = 8'h88;
      4'hB: hex_pat = 8'h83;
      4'hC: hex_pat = 8'hC6;
      4'hD: hex_pat = 8'hA1;
      4'hE: hex_pat = 8'h86;
      4'hF: hex_pat = 8'h8E;
      default: hex_pat = 8'hFF;
    endcase
  end

  // Raw mode only has four bytes; in hex mode a digit is a leading zero when
  // it and every nibble above it are zero (digit 0 always stays lit).
  always_comb begin
    digit_off = 1'b0;
    if (mode_q) begin
      digit_off = idx_q[2];
    end else if (LZB != 0) begin
      digit_off = (idx_q != 3'd0) && ((shadow_q >> {idx_q, 2'b00}) == 32'd0);
    end
  end

  assign slot_off = (cnt_q < CW'(GHOST_CYC)) || blank || digit_off;

  always_comb begin
    cnt_d    = tick ? '0 : cnt_q + CW'(1);
    idx_d    = tick ? idx_q + 3'd1 : idx_q;
    shadow_d = frame_tick ? i_data : shadow_q;
    mode_d   = frame_tick ? disp_mode : mode_q;
    frame_d  = frame_tick;
    sel_d    = 8'hFF;
    seg_d    = 8'hFF;
    if (!slot_off) begin
      sel_d = ~(8'b1 << idx_q);
      seg_d = mode_q ? raw_byte : hex_pat;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q    <= '0;
      idx_q    <= 3'd0;
      shadow_q <= 32'd0;
      mode_q   <= 1'b0;
      seg_q    <= 8'hFF;
      sel_q    <= 8'hFF;
      frame_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      mode_q   <= mode_d;
      seg_q    <= seg_d;
      sel_q    <= sel_d;
      frame_q  <= frame_d;
    end
  end

  assign o_seg   = seg_q;
  assign o_sel   = sel_q;
  assign o_frame = frame_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: LZB=0 and LZB=1 instances share stimulus and are checked
// every cycle against a time-based model, plus literal digit expectations.
module tb_seg7_scan_ctrl;

  localparam int SD = 8;
  localparam int GC = 2;

  // clock / reset
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] i_data = 32'd0;
  logic        disp_mode = 1'b0;
  logic        blank = 1'b0;
  logic [7:0]  seg0, sel0, seg1, sel1;
  logic        frame0, frame1;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.SCAN_DIV(SD), .GHOST_CYC(GC), .LZB(0)) dut0 (
    .clk(clk), .rstn(rstn), .i_data(i_data), .disp_mode(disp_mode), .blank(blank),
    .o_seg(seg0), .o_sel(sel0), .o_frame(frame0)
  );

  seg7_scan_ctrl #(.SCAN_DIV(SD), .GHOST_CYC(GC), .LZB(1)) dut1 (
    .clk(clk), .rstn(rstn), .i_data(i_data), .disp_mode(disp_mode), .blank(blank),
    .o_seg(seg1), .o_sel(sel1), .o_frame(frame1)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: n counts clock edges since reset release, so the slot
  // position and digit follow directly from n by division.
  logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  int          n = 0;
  int          m_c, m_d;
  logic [31:0] m_shadow = 32'd0;
  logic        m_mode = 1'b0;
  logic [7:0]  e_sel [2] = '{8'hFF, 8'hFF};
  logic [7:0]  e_seg [2] = '{8'hFF, 8'hFF};
  logic        e_frame = 1'b0;

  function automatic void model_out(input int c, input int d, input logic [31:0] sh,
                                    input logic md, input logic blk, input bit lzb,
                                    output logic [7:0] sel, output logic [7:0] seg);
    bit off;
    off = (c < GC) || blk;
    if (md) off = off || (d >= 4);
    else if (lzb && d > 0 && (sh >> (4 * d)) == 32'd0) off = 1'b1;
    if (off) begin
      sel = 8'hFF;
      seg = 8'hFF;
    end else begin
      sel = ~(8'b1 << d);
      seg = md ? sh[8 * d +: 8] : hex_tab[sh[4 * d +: 4]];
    end
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      n        = 0;
      m_shadow = 32'd0;
      m_mode   = 1'b0;
      e_sel    = '{8'hFF, 8'hFF};
      e_seg    = '{8'hFF, 8'hFF};
      e_frame  = 1'b0;
    end else begin
      m_c = n % SD;
      m_d = (n / SD) % 8;
      model_out(m_c, m_d, m_shadow, m_mode, blank, 1'b0, e_sel[0], e_seg[0]);
      model_out(m_c, m_d, m_shadow, m_mode, blank, 1'b1, e_sel[1], e_seg[1]);
      e_frame = (m_c == SD - 1) && (m_d == 7);
      if (e_frame) begin
        m_shadow = i_data;
        m_mode   = disp_mode;
      end
      n++;
    end
  end

  // scoreboard: every cycle, away from the active edge
  always @(negedge clk) begin
    check("sel_lzb0", {24'd0, sel0}, {24'd0, e_sel[0]});
    check("seg_lzb0", {24'd0, seg0}, {24'd0, e_seg[0]});
    check("sel_lzb1", {24'd0, sel1}, {24'd0, e_sel[1]});
    check("seg_lzb1", {24'd0, seg1}, {24'd0, e_seg[1]});
    check("frame0", {31'd0, frame0}, {31'd0, e_frame});
    check("frame1", {31'd0, frame1}, {31'd0, e_frame});
  end

  // driver tasks
  task automatic wait_frame(input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (frame0) found = 1'b1;
    end
    if (!found) begin
      tests++;
      fails++;
      $display("FAIL %s: no o_frame within 200 cycles, expected a pulse", name);
    end
  endtask

  task automatic digit_check(input int inst, input int k, input logic [7:0] exp, input string name);
    logic [7:0] want;
    bit         found;
    want  = ~(8'b1 << k);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (((inst == 0) ? sel0 : sel1) == want) found = 1'b1;
    end
    if (!found) begin
      tests++;
      fails++;
      $display("FAIL %s: digit %0d never enabled, expected o_sel=%h", name, k, want);
    end else begin
      check(name, {24'd0, (inst == 0) ? seg0 : seg1}, {24'd0, exp});
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] hex_exp [8];
    hex_exp = '{8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80};

    // reset
    repeat (3) @(negedge clk);
    check("rst_sel", {24'd0, sel0}, 32'h0000_00FF);
    check("rst_seg", {24'd0, seg0}, 32'h0000_00FF);
    check("rst_frame", {31'd0, frame0}, 32'd0);
    rstn = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("first_sel", {24'd0, sel0}, 32'h0000_00FE);
    check("first_seg", {24'd0, seg0}, 32'h0000_00C0);

    // hex scan
    i_data = 32'h89AB_CDEF;
    disp_mode = 1'b0;
    wait_frame("hex_frame");
    for (int k = 0; k < 8; k++) digit_check(0, k, hex_exp[k], "hex_digit");

    // tear-free capture
    i_data = 32'h1234_5678;
    wait_frame("tear_frame");
    digit_check(0, 3, 8'h92, "tear_d3");
    i_data = 32'd0;
    digit_check(0, 4, 8'h99, "tear_d4");
    digit_check(0, 5, 8'hB0, "tear_d5");
    digit_check(0, 6, 8'hA4, "tear_d6");
    digit_check(0, 7, 8'hF9, "tear_d7");
    wait_frame("tear_next");
    digit_check(0, 0, 8'hC0, "tear_new_d0");
    digit_check(0, 7, 8'hC0, "tear_new_d7");

    // raw mode
    disp_mode = 1'b1;
    i_data = 32'h7F00_FFC0;
    wait_frame("raw_frame");
    digit_check(0, 0, 8'hC0, "raw_d0");
    digit_check(0, 1, 8'hFF, "raw_d1");
    digit_check(0, 2, 8'h00, "raw_d2");
    digit_check(0, 3, 8'h7F, "raw_d3");

    // leading-zero blanking
    disp_mode = 1'b0;
    i_data = 32'h0000_00A0;
    wait_frame("lzb_frame");
    digit_check(1, 0, 8'hC0, "lzb_d0");
    digit_check(1, 1, 8'h88, "lzb_d1");
    i_data = 32'd0;
    wait_frame("lzb_zero_frame");
    digit_check(1, 0, 8'hC0, "lzb_zero_d0");

    // blank
    @(negedge clk);
    blank = 1'b1;
    @(negedge clk);
    check("blank_sel", {24'd0, sel0}, 32'h0000_00FF);
    repeat (19) @(negedge clk);
    blank = 1'b0;
    i_data = 32'h89AB_CDEF;
    repeat (20) @(negedge clk);

    // randomized traffic
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 19) == 0) i_data = $urandom >> ($urandom_range(0, 8) * 4);
      if ($urandom_range(0, 39) == 0) disp_mode = ~disp_mode;
      blank = ($urandom_range(0, 15) == 0);
    end
    blank = 1'b0;

    // reset mid-slot at cnt=5
    for (int i = 0; i < 20 && (n % SD) != 5; i++) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check("mid_rst_sel", {24'd0, sel0}, 32'h0000_00FF);
    check("mid_rst_seg", {24'd0, seg0}, 32'h0000_00FF);
    check("mid_rst_frame", {31'd0, frame0}, 32'd0);
    @(negedge clk);
    #2 rstn = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("restart_sel", {24'd0, sel0}, 32'h0000_00FE);
    check("restart_seg", {24'd0, seg0}, 32'h0000_00C0);
    repeat (70) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
